// File: rtl/audio_pkg.sv
// Shared encodings and default timing for the codec power/config sequencer.
// Defaults assume clk_256fs at roughly 12 MHz.
package audio_pkg;

  localparam logic [2:0] ST_PDN      = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_CFG_REQ  = 3'd2;
  localparam logic [2:0] ST_CFG_WAIT = 3'd3;
  localparam logic [2:0] ST_ALIGN    = 3'd4;
  localparam logic [2:0] ST_RUN      = 3'd5;
  localparam logic [2:0] ST_FAULT    = 3'd6;

  // ~0.34 ms power-down, ~0.68 ms settle, ~87 ms config timeout at 12 MHz
  localparam int PDN_LOW_CYCLES_DEF = 1 << 12;
  localparam int SETTLE_CYCLES_DEF  = 1 << 13;
  localparam int CFG_TIMEOUT_DEF    = 1 << 20;

endpackage

// File: rtl/codec_pwr_seq_timer.sv
// Up-counter shared by the timed states; clears on state entry and flags
// the terminal count selected by the FSM.
module seq_timer #(
  parameter int CNT_W = 21
) (
  input  logic             clk_256fs,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_256fs or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == last);

endmodule

// File: rtl/codec_pwr_seq.sv
// Codec power-up / configuration sequencer: power-down hold, settle, supervised
// I2C configuration with bounded retry, and fs-aligned datapath reset release.
module codec_pwr_seq
  import audio_pkg::*;
#(
  parameter int PDN_LOW_CYCLES = PDN_LOW_CYCLES_DEF,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int CFG_TIMEOUT    = CFG_TIMEOUT_DEF,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 21
) (
  input  logic       clk_256fs,
  input  logic       rst,
  input  logic       fs_strobe,
  input  logic       cfg_busy,
  input  logic       cfg_done,
  input  logic       cfg_err,
  input  logic       recal_req,
  output logic       cfg_start,
  output logic       codec_pdn,
  output logic       dsp_rst,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRIES);

  logic [2:0]       state_q, state_d;
  logic             cfg_start_q, cfg_start_d;
  logic             codec_pdn_q, codec_pdn_d;
  logic             dsp_rst_q, dsp_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic [1:0]       retry_cnt_q, retry_cnt_d;

  logic             tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_last;

  always_comb begin
    tmr_last = '0;
    tmr_en   = 1'b0;
    case (state_q)
      ST_PDN: begin
        tmr_last = CNT_W'(PDN_LOW_CYCLES - 1);
        tmr_en   = 1'b1;
      end
      ST_SETTLE: begin
        tmr_last = CNT_W'(SETTLE_CYCLES - 1);
        tmr_en   = 1'b1;
      end
      ST_CFG_WAIT: begin
        tmr_last = CNT_W'(CFG_TIMEOUT - 1);
        tmr_en   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cfg_start_d = 1'b0;
    codec_pdn_d = codec_pdn_q;
    dsp_rst_d   = dsp_rst_q;
    ready_d     = ready_q;
    fault_d     = fault_q;
    retry_cnt_d = retry_cnt_q;

    // Recalibration overrides everything, including an in-flight config
    if (recal_req) begin
      state_d     = ST_PDN;
      codec_pdn_d = 1'b0;
      dsp_rst_d   = 1'b1;
      ready_d     = 1'b0;
      fault_d     = 1'b0;
      retry_cnt_d = '0;
    end else begin
      case (state_q)
        ST_PDN: begin
          codec_pdn_d = 1'b0;
          dsp_rst_d   = 1'b1;
          if (tmr_tc) begin
            codec_pdn_d = 1'b1;
            state_d     = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_tc) state_d = ST_CFG_REQ;
        end
        ST_CFG_REQ: begin
          if (!cfg_busy) begin
            cfg_start_d = 1'b1;
            state_d     = ST_CFG_WAIT;
          end
        end
        ST_CFG_WAIT: begin
          // An error reported alongside done still counts as a failure
          if (cfg_err || (tmr_tc && !cfg_done)) begin
            codec_pdn_d = 1'b0;
            if (retry_cnt_q < RETRY_MAX) begin
              retry_cnt_d = retry_cnt_q + 2'd1;
              state_d     = ST_PDN;
            end else begin
              fault_d = 1'b1;
              state_d = ST_FAULT;
            end
          end else if (cfg_done) begin
            state_d = ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (fs_strobe) begin
            dsp_rst_d = 1'b0;
            ready_d   = 1'b1;
            state_d   = ST_RUN;
          end
        end
        ST_RUN: ;
        ST_FAULT: begin
          fault_d     = 1'b1;
          codec_pdn_d = 1'b0;
          dsp_rst_d   = 1'b1;
          ready_d     = 1'b0;
        end
        default: begin
          state_d     = ST_PDN;
          codec_pdn_d = 1'b0;
          dsp_rst_d   = 1'b1;
          ready_d     = 1'b0;
          fault_d     = 1'b0;
          retry_cnt_d = '0;
        end
      endcase
    end
  end

  assign tmr_clr = recal_req || (state_d != state_q);

  seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_256fs(clk_256fs),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .last     (tmr_last),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk_256fs or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PDN;
      cfg_start_q <= 1'b0;
      codec_pdn_q <= 1'b0;
      dsp_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cfg_start_q <= cfg_start_d;
      codec_pdn_q <= codec_pdn_d;
      dsp_rst_q   <= dsp_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign state     = state_q;
  assign cfg_start = cfg_start_q;
  assign codec_pdn = codec_pdn_q;
  assign dsp_rst   = dsp_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_codec_pwr_seq.sv
// Self-checking bench for codec_pwr_seq: nominal vector table, hand-written
// corner sequences, and randomized traffic against a phase-level model.
module tb_codec_pwr_seq;

  localparam int PDN_N  = 4;
  localparam int SET_N  = 8;
  localparam int TMO_N  = 16;
  localparam int MAXR   = 2;

  localparam int P_PDN = 0, P_SETTLE = 1, P_REQ = 2, P_WAIT = 3;
  localparam int P_ALIGN = 4, P_RUN = 5, P_FAULT = 6;

  logic       clk_256fs = 1'b0;
  logic       rst = 1'b1;
  logic       fs_strobe = 1'b0;
  logic       cfg_busy = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cfg_err = 1'b0;
  logic       recal_req = 1'b0;
  logic       cfg_start, codec_pdn, dsp_rst, ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  codec_pwr_seq #(
    .PDN_LOW_CYCLES(PDN_N),
    .SETTLE_CYCLES (SET_N),
    .CFG_TIMEOUT   (TMO_N),
    .MAX_RETRIES   (MAXR),
    .CNT_W         (8)
  ) dut (
    .clk_256fs(clk_256fs),
    .rst      (rst),
    .fs_strobe(fs_strobe),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .recal_req(recal_req),
    .cfg_start(cfg_start),
    .codec_pdn(codec_pdn),
    .dsp_rst  (dsp_rst),
    .ready    (ready),
    .fault    (fault),
    .retry_cnt(retry_cnt),
    .state    (state)
  );

  always #5 clk_256fs = ~clk_256fs;

  int n_chk = 0;
  int n_fail = 0;
  int fs_cnt = 0;
  int cyc = 0;
  logic last_fs = 1'b0;

  // Model: a phase plus cycles remaining in that phase; outputs follow the phase.
  int m_ph, m_left, m_retry;
  bit m_start;

  typedef struct {
    int         rep;
    logic       busy, done, err;
    logic [2:0] st;
    logic       pdn, dsp, rdy, flt, start;
    logic [1:0] rty;
  } vec_t;

  vec_t nom [7];

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endfunction

  function automatic int dur(int p);
    case (p)
      P_PDN:    return PDN_N;
      P_SETTLE: return SET_N;
      P_WAIT:   return TMO_N;
      default:  return 0;
    endcase
  endfunction

  function automatic void enter(int p);
    m_ph   = p;
    m_left = dur(p);
  endfunction

  function automatic void model_reset();
    m_retry = 0;
    m_start = 0;
    enter(P_PDN);
  endfunction

  function automatic void model_step(logic b, logic d, logic e, logic r, logic fs);
    m_start = 0;
    if (r) begin
      m_retry = 0;
      enter(P_PDN);
      return;
    end
    case (m_ph)
      P_PDN: begin
        if (m_left == 1) enter(P_SETTLE);
        else m_left--;
      end
      P_SETTLE: begin
        if (m_left == 1) enter(P_REQ);
        else m_left--;
      end
      P_REQ: begin
        if (!b) begin
          m_start = 1;
          enter(P_WAIT);
        end
      end
      P_WAIT: begin
        if (e || (m_left == 1 && !d)) begin
          if (m_retry < MAXR) begin
            m_retry++;
            enter(P_PDN);
          end else begin
            enter(P_FAULT);
          end
        end else if (d) begin
          enter(P_ALIGN);
        end else begin
          m_left--;
        end
      end
      P_ALIGN: begin
        if (fs) enter(P_RUN);
      end
      default: ;
    endcase
  endfunction

  task automatic step(input logic b, input logic d, input logic e, input logic r);
    cfg_busy  = b;
    cfg_done  = d;
    cfg_err   = e;
    recal_req = r;
    fs_strobe = (fs_cnt == 255);
    last_fs   = fs_strobe;
    @(posedge clk_256fs);
    model_step(b, d, e, r, last_fs);
    fs_cnt = (fs_cnt + 1) % 256;
    cyc++;
    #1;
    cfg_done  = 1'b0;
    cfg_err   = 1'b0;
    recal_req = 1'b0;
    fs_strobe = 1'b0;
    chk("model_state", 32'(state), 32'(m_ph));
    chk("model_cfg_start", 32'(cfg_start), 32'(m_start));
    chk("model_codec_pdn", 32'(codec_pdn), 32'(m_ph >= P_SETTLE && m_ph <= P_RUN));
    chk("model_dsp_rst", 32'(dsp_rst), 32'(m_ph != P_RUN));
    chk("model_ready", 32'(ready), 32'(m_ph == P_RUN));
    chk("model_fault", 32'(fault), 32'(m_ph == P_FAULT));
    chk("model_retry_cnt", 32'(retry_cnt), 32'(m_retry));
  endtask

  // Entered and left 1 time unit after a rising edge; rst rises between edges.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    fs_cnt = 0;
    cyc = 0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_codec_pdn", 32'(codec_pdn), 0);
    chk("rst_dsp_rst", 32'(dsp_rst), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_cfg_start", 32'(cfg_start), 0);
    chk("rst_retry_cnt", 32'(retry_cnt), 0);
    @(posedge clk_256fs);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_to_start();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(0, 0, 0, 0);
      if (cfg_start) seen = 1;
    end
    chk("reach_cfg_start", 32'(seen), 1);
  endtask

  task automatic wait_ready();
    bit seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      step(0, 0, 0, 0);
      if (ready) seen = 1;
    end
    chk("reach_ready", 32'(seen), 1);
  endtask

  task automatic run_nominal();
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < nom[v].rep; k++) begin
        step(nom[v].busy, nom[v].done, nom[v].err, 0);
        chk($sformatf("nom%0d_state", v), 32'(state), 32'(nom[v].st));
        chk($sformatf("nom%0d_pdn", v), 32'(codec_pdn), 32'(nom[v].pdn));
        chk($sformatf("nom%0d_dsp", v), 32'(dsp_rst), 32'(nom[v].dsp));
        chk($sformatf("nom%0d_ready", v), 32'(ready), 32'(nom[v].rdy));
        chk($sformatf("nom%0d_fault", v), 32'(fault), 32'(nom[v].flt));
        chk($sformatf("nom%0d_start", v), 32'(cfg_start), 32'(nom[v].start));
        chk($sformatf("nom%0d_retry", v), 32'(retry_cnt), 32'(nom[v].rty));
      end
    end
    wait_ready();
    chk("nom_ready_after_fs", 32'(last_fs), 1);
    chk("nom_ready_cycle", 32'(cyc), 256);
    chk("nom_dsp_rst_low", 32'(dsp_rst), 0);
    chk("nom_retry_zero", 32'(retry_cnt), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, starts, last_start;
    logic [2:0] prev_st;

    // Edge counts are from reset release: pdn rises at edge 4, CFG_REQ at 12,
    // cfg_start after edge 13, cfg_done sampled at edge 19.
    nom[0] = '{3, 0, 0, 0, 3'd0, 0, 1, 0, 0, 0, 2'd0};
    nom[1] = '{1, 0, 0, 0, 3'd1, 1, 1, 0, 0, 0, 2'd0};
    nom[2] = '{7, 0, 0, 0, 3'd1, 1, 1, 0, 0, 0, 2'd0};
    nom[3] = '{1, 0, 0, 0, 3'd2, 1, 1, 0, 0, 0, 2'd0};
    nom[4] = '{1, 0, 0, 0, 3'd3, 1, 1, 0, 0, 1, 2'd0};
    nom[5] = '{5, 0, 0, 0, 3'd3, 1, 1, 0, 0, 0, 2'd0};
    nom[6] = '{1, 0, 1, 0, 3'd4, 1, 1, 0, 0, 0, 2'd0};

    @(posedge clk_256fs);
    #1;

    // Nominal
    do_reset();
    run_nominal();

    // Busy hold-off
    do_reset();
    repeat (12) step(0, 0, 0, 0);
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0);
      if (cfg_start) starts++;
    end
    chk("busy_no_start", 32'(starts), 0);
    chk("busy_held_req", 32'(state), 2);
    step(0, 0, 0, 0);
    chk("busy_start_on_drop", 32'(cfg_start), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      if (cfg_start) starts++;
    end
    chk("busy_single_pulse", 32'(starts), 0);

    // Retry then success
    do_reset();
    run_to_start();
    step(0, 0, 1, 0);
    chk("retry_back_to_pdn", 32'(state), 0);
    chk("retry_pdn_dropped", 32'(codec_pdn), 0);
    chk("retry_cnt_one", 32'(retry_cnt), 1);
    low = 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      if (codec_pdn) break;
      low++;
    end
    chk("retry_pdn_low_cycles", 32'(low), 4);
    run_to_start();
    repeat (4) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("retry_align", 32'(state), 4);
    wait_ready();
    chk("retry_run_cnt", 32'(retry_cnt), 1);
    chk("retry_run_ready", 32'(ready), 1);

    // Timeout exhaustion
    do_reset();
    starts = 0;
    last_start = 0;
    prev_st = 3'd0;
    for (int i = 0; i < 150; i++) begin
      step(0, 0, 0, 0);
      if (cfg_start) begin
        starts++;
        last_start = cyc;
      end
      if (prev_st == 3'd3 && state != 3'd3)
        chk("timeout_latency", 32'(cyc - last_start), 16);
      prev_st = state;
    end
    chk("timeout_start_count", 32'(starts), 3);
    chk("timeout_fault_state", 32'(state), 6);
    chk("timeout_fault", 32'(fault), 1);
    chk("timeout_pdn_low", 32'(codec_pdn), 0);
    chk("timeout_retry_cnt", 32'(retry_cnt), 2);
    step(0, 0, 0, 1);
    chk("fault_recal_state", 32'(state), 0);
    chk("fault_recal_clear", 32'(fault), 0);

    // Simultaneous done+err, then recal from RUN
    do_reset();
    run_to_start();
    step(0, 1, 1, 0);
    chk("both_is_failure", 32'(state), 0);
    chk("both_retry_inc", 32'(retry_cnt), 1);
    run_to_start();
    step(0, 1, 0, 0);
    wait_ready();
    step(0, 0, 0, 1);
    chk("recal_state", 32'(state), 0);
    chk("recal_ready", 32'(ready), 0);
    chk("recal_dsp_rst", 32'(dsp_rst), 1);
    chk("recal_pdn", 32'(codec_pdn), 0);
    chk("recal_retry", 32'(retry_cnt), 0);
    low = 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      if (codec_pdn) break;
      low++;
    end
    chk("recal_pdn_low_cycles", 32'(low), 4);

    // Async reset mid CFG_WAIT, then nominal timing again
    do_reset();
    run_to_start();
    repeat (3) step(0, 0, 0, 0);
    chk("pre_rst_in_wait", 32'(state), 3);
    do_reset();
    run_nominal();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic b, d, e, r;
      b = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 399) == 0);
      step(b, d, e, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
